// File: rtl/usr_rst_req.sv
// usr_rst_req
//   Watches the UART receive byte stream for a 4-byte magic sequence and, on
//   a match, issues a fixed-width usr_rst pulse to the core reset generator.
//   On the last pulse cycle it checks that the reset generator has latched
//   the request (rst_state). It then ignores receive traffic for a holdoff
//   window before it starts matching again.
//
// Ports
//   clk        system clock
//   rstn       synchronous active-low reset (board-level sys_rstn)
//   rx_valid   one-cycle strobe: rx_data holds a received byte
//   rx_data    received byte
//   rst_state  latched state_out from the reset generator
//   usr_rst    reset request to the reset generator (registered)
//   busy       high while pulsing or in holdoff (registered)
//   ack_err    sticky: rst_state was still 0 on the last pulse cycle
module usr_rst_req #(
    parameter logic [31:0] MAGIC     = 32'h52535421,
    parameter int          PULSE_LEN = 16,
    parameter int          HOLDOFF   = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rst_state,
    output logic       usr_rst,
    output logic       busy,
    output logic       ack_err
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Magic split into bytes, byte 0 being the first byte on the wire.
    logic [7:0] magic_byte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_magic
            assign magic_byte[gi] = MAGIC[8*(3-gi)+7 -: 8];
        end
    endgenerate

    logic [1:0]    state_reg,     state_next;
    logic [1:0]    idx_reg,       idx_next;
    logic [PW-1:0] pulse_cnt_reg, pulse_cnt_next;
    logic [HW-1:0] hold_cnt_reg,  hold_cnt_next;
    logic          usr_rst_reg,   usr_rst_next;
    logic          busy_reg,      busy_next;
    logic          ack_err_reg,   ack_err_next;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        pulse_cnt_next = pulse_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        usr_rst_next   = usr_rst_reg;
        busy_next      = busy_reg;
        ack_err_next   = ack_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == magic_byte[idx_reg]) begin
                        if (idx_reg == 2'd3) begin
                            // Outputs are registered, so raising them here
                            // makes the first high cycle the one right after
                            // the edge that accepted the last magic byte.
                            state_next     = ST_PULSE;
                            pulse_cnt_next = '0;
                            idx_next       = 2'd0;
                            usr_rst_next   = 1'b1;
                            busy_next      = 1'b1;
                        end else begin
                            idx_next = idx_reg + 2'd1;
                        end
                    end else if (rx_data == magic_byte[0]) begin
                        // A broken match may itself start a new one.
                        idx_next = 2'd1;
                    end else begin
                        idx_next = 2'd0;
                    end
                end
            end

            ST_PULSE: begin
                if (pulse_cnt_reg == PULSE_LAST) begin
                    // The reset generator must have latched the request by
                    // the final pulse cycle.
                    if (!rst_state) begin
                        ack_err_next = 1'b1;
                    end
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                    usr_rst_next  = 1'b0;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg + PW'(1);
                end
            end

            ST_HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_IDLE;
                    idx_next   = 2'd0;
                    busy_next  = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end

            default: begin
                state_next   = ST_IDLE;
                idx_next     = 2'd0;
                usr_rst_next = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 2'd0;
            pulse_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            usr_rst_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            pulse_cnt_reg <= pulse_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            usr_rst_reg   <= usr_rst_next;
            busy_reg      <= busy_next;
            ack_err_reg   <= ack_err_next;
        end
    end

    assign usr_rst = usr_rst_reg;
    assign busy    = busy_reg;
    assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_usr_rst_req.sv
// Testbench for usr_rst_req: a directed vector table, hand-written sequences
// for the multi-cycle cases, and random traffic. Every cycle is also checked
// against a window-based reference model.
module tb_usr_rst_req;

    localparam int P = 16;
    localparam int H = 1024;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rst_state = 1'b1;
    logic       usr_rst;
    logic       busy;
    logic       ack_err;

    usr_rst_req #(
        .MAGIC    (32'h52535421),
        .PULSE_LEN(P),
        .HOLDOFF  (H)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rst_state(rst_state),
        .usr_rst  (usr_rst),
        .busy     (busy),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] magic = 32'h52535421;

    function automatic logic [7:0] mbyte(input int i);
        return magic[8*(3-i)+7 -: 8];
    endfunction

    // Reference model: a match is "the last four bytes accepted while idle
    // spell the magic". A trigger opens a usr_rst window of P cycles and a
    // busy window of P+H cycles; the model simply counts those down.
    logic [7:0] hist[$];
    int         m_pulse_left = 0;
    int         m_busy_left  = 0;
    logic       m_ack        = 1'b0;

    task automatic model_update(input logic r, input logic v, input logic [7:0] d,
                                input logic rs);
        if (!r) begin
            hist.delete();
            m_pulse_left = 0;
            m_busy_left  = 0;
            m_ack        = 1'b0;
        end else if (m_busy_left > 0) begin
            if (m_pulse_left == 1 && !rs) m_ack = 1'b1;
            if (m_pulse_left > 0) m_pulse_left--;
            m_busy_left--;
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == magic) begin
                m_pulse_left = P;
                m_busy_left  = P + H;
                hist.delete();
            end
        end
    endtask

    logic cur_rs = 1'b1;

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rs);
        logic eu, eb;
        rstn = r; rx_valid = v; rx_data = d; rst_state = rs;
        @(posedge clk);
        model_update(r, v, d, rs);
        @(negedge clk);
        eu = (m_pulse_left > 0);
        eb = (m_busy_left > 0);
        n_vec++;
        if ({usr_rst, busy, ack_err} !== {eu, eb, m_ack}) begin
            n_err++;
            $display("FAIL model t=%0t usr/busy/ack actual=%b%b%b required=%b%b%b",
                     $time, usr_rst, busy, ack_err, eu, eb, m_ack);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(1'b1, 1'b1, b, cur_rs);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00, cur_rs);
    endtask

    task automatic send_magic();
        for (int k = 0; k < 4; k++) send_byte(mbyte(k));
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       eu;
        logic       eb;
        logic       ea;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic eu, input logic eb, input logic ea);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.eu = eu; t.eb = eb; t.ea = ea;
        return t;
    endfunction

    initial begin
        int hi, bz, changes, rises;
        logic prev_u;

        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h52, 0, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(1, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(1, 1, 8'h52, 0, 0, 0);
        tbl[5]  = mk(1, 1, 8'h53, 0, 0, 0);
        tbl[6]  = mk(1, 1, 8'h00, 0, 0, 0);
        tbl[7]  = mk(1, 1, 8'h54, 0, 0, 0);
        tbl[8]  = mk(1, 1, 8'h21, 0, 0, 0);   // broken sequence: no pulse
        tbl[9]  = mk(1, 1, 8'h52, 0, 0, 0);
        tbl[10] = mk(1, 1, 8'h52, 0, 0, 0);   // repeated first byte restarts
        tbl[11] = mk(1, 1, 8'h53, 0, 0, 0);
        tbl[12] = mk(1, 1, 8'h54, 0, 0, 0);
        tbl[13] = mk(1, 1, 8'h21, 1, 1, 0);   // pulse starts next cycle
        tbl[14] = mk(1, 0, 8'h00, 1, 1, 0);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 0);   // reset during pulse
        tbl[16] = mk(1, 1, 8'h53, 0, 0, 0);
        tbl[17] = mk(1, 1, 8'h54, 0, 0, 0);
        tbl[18] = mk(1, 1, 8'h21, 0, 0, 0);   // index was cleared: no pulse

        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, 1'b1);
            n_vec++;
            if ({usr_rst, busy, ack_err} !== {tbl[i].eu, tbl[i].eb, tbl[i].ea}) begin
                n_err++;
                $display("FAIL table[%0d] usr/busy/ack actual=%b%b%b required=%b%b%b",
                         i, usr_rst, busy, ack_err, tbl[i].eu, tbl[i].eb, tbl[i].ea);
            end else begin
                $display("vec %0d rstn=%b v=%b d=%h -> %b%b%b ok", i, tbl[i].r,
                         tbl[i].v, tbl[i].d, usr_rst, busy, ack_err);
            end
        end

        // Reset for 3 cycles, then 100 quiet cycles with no output change.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        changes = 0;
        for (int k = 0; k < 100; k++) begin
            idle(1);
            changes += int'(usr_rst) + int'(busy) + int'(ack_err);
        end
        check("quiet_idle_outputs", changes, 0);

        // Clean match with 10-cycle gaps.
        cur_rs = 1'b1;
        send_byte(8'h52); idle(10);
        send_byte(8'h53); idle(10);
        send_byte(8'h54); idle(10);
        send_byte(8'h21);
        check("gap10_first_high", usr_rst, 1);
        hi = 1; bz = 1;
        for (int k = 0; k < 1100; k++) begin
            idle(1);
            hi += int'(usr_rst);
            bz += int'(busy);
        end
        check("gap10_pulse_len", hi, P);
        check("gap10_busy_len", bz, P + H);
        check("gap10_ack_err", ack_err, 0);

        // Clean match, back-to-back bytes.
        send_magic();
        check("gap0_first_high", usr_rst, 1);
        hi = 1;
        for (int k = 0; k < 1100; k++) begin
            idle(1);
            hi += int'(usr_rst);
        end
        check("gap0_pulse_len", hi, P);

        // Second magic during HOLD is ignored.
        send_magic();
        hi = 1; rises = 1; prev_u = 1'b1;
        idle(50);
        hi += 0;
        send_magic();
        for (int k = 0; k < 1100; k++) begin
            idle(1);
            hi += int'(usr_rst);
            if (usr_rst && !prev_u) rises++;
            prev_u = usr_rst;
        end
        check("holdoff_pulses", rises, 1);
        check("holdoff_busy_done", busy, 0);
        send_magic();
        check("after_holdoff_pulse", usr_rst, 1);
        idle(1100);

        // Ack failure is sticky until reset.
        cur_rs = 1'b0;
        send_magic();
        idle(P - 1);
        check("ack_err_before_last", ack_err, 0);
        idle(1);
        check("ack_err_set", ack_err, 1);
        idle(1100);
        cur_rs = 1'b1;
        send_magic();
        check("ack_err_retrigger", usr_rst, 1);
        idle(1100);
        check("ack_err_sticky", ack_err, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("ack_err_cleared", ack_err, 0);

        // Reset on pulse cycle 5.
        send_magic();
        idle(4);
        check("mid_pulse_high", usr_rst, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("mid_pulse_rst_usr", usr_rst, 0);
        check("mid_pulse_rst_busy", busy, 0);
        send_byte(8'h53); send_byte(8'h54); send_byte(8'h21);
        idle(2);
        check("partial_after_rst", usr_rst, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 400 == 0) begin
                send_magic();
            end else begin
                logic       r, v, rs;
                logic [7:0] d;
                r  = ($urandom % 300) != 0;
                v  = ($urandom % 3) == 0;
                d  = ($urandom % 4 != 0) ? mbyte(int'($urandom % 4)) : 8'($urandom);
                rs = ($urandom % 6) != 0;
                step(r, v, d, rs);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
